// File: rtl/bip_control_unit.sv
// BIP fetch/decode control: PC, IDLE/RUN/HALTED sequencing, combinational datapath controls.
// Latency: controls valid in the same cycle as PcAddr. No backpressure; one instruction per RUN cycle.
// Optional cycle counter enabled by defining BIP_CYCLE_COUNT_EN (otherwise CycleCount is tied to 0).
module bip_control_unit #(
  parameter int PC_W   = 11,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Instr,
  output logic [PC_W-1:0]   PcAddr,
  output logic [PC_W-1:0]   Addr,
  output logic [1:0]        SelA,
  output logic              SelB,
  output logic              Op,
  output logic              WrAcc,
  output logic              WrRam,
  output logic              RdRam,
  output logic              Busy,
  output logic              Halted,
  output logic [CNT_W-1:0]  CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [OPC_W-1:0] OPC_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_SUBI = OPC_W'(7);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [OPC_W-1:0]  opcode;

  assign opcode = Instr[DATA_W-1 -: OPC_W];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        // HLT parks the PC on the halt instruction itself
        if (opcode == OPC_HLT) begin
          state_d = S_HALTED;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_comb begin
    SelA  = 2'd0;
    SelB  = 1'b0;
    Op    = 1'b0;
    WrAcc = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    if (state_q == S_RUN) begin
      case (opcode)
        OPC_STO:  WrRam = 1'b1;
        OPC_LD:   begin RdRam = 1'b1; WrAcc = 1'b1; end
        OPC_LDI:  begin SelA = 2'd1; WrAcc = 1'b1; end
        OPC_ADD:  begin RdRam = 1'b1; SelA = 2'd2; WrAcc = 1'b1; end
        OPC_ADDI: begin SelA = 2'd2; SelB = 1'b1; WrAcc = 1'b1; end
        OPC_SUB:  begin RdRam = 1'b1; SelA = 2'd2; Op = 1'b1; WrAcc = 1'b1; end
        OPC_SUBI: begin SelA = 2'd2; SelB = 1'b1; Op = 1'b1; WrAcc = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_RUN && Start) begin
      cnt_d = '0;
    end else if (state_q == S_RUN && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CycleCount = cnt_q;
`else
  assign CycleCount = '0;
`endif

  assign PcAddr = pc_q;
  assign Addr   = Instr[PC_W-1:0];
  assign Busy   = (state_q == S_RUN);
  assign Halted = (state_q == S_HALTED);

endmodule
